// File: rtl/sccb_responder.sv
// SCCB write-only responder emulating the OV7670 register port: decodes ID/address/data
// writes, acknowledges by pulling SIOD low and commits each write into a 256x8 register file.
module sccb_responder #(
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter int         ACK_DLY  = 80,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic        ov7670_clk50,
  input  logic        reg_conf_rst,
  input  logic        sioc,
  inout  wire         siod,
  output logic        busy,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        id_err,
  output logic [15:0] wr_count,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data
);
  typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_DATA, S_IGNORE} state_t;
  typedef enum logic [1:0] {A_NONE, A_WAIT, A_COUNT, A_DRIVE} ack_t;

  localparam logic [7:0] ACK_LAST = 8'(ACK_DLY - 1);

  logic [2:0]  sioc_sync_q, sioc_sync_d, siod_sync_q, siod_sync_d;
  state_t      state_q, state_d;
  ack_t        ack_q, ack_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic        siod_oe_q, siod_oe_d;
  logic        wr_en_q, wr_en_d, id_err_q, id_err_d;
  logic [7:0]  wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  regs_q [256];
  logic        reg_we;
  logic [7:0]  rx_byte;
  logic        sioc_rise, sioc_fall, sioc_hi, start_det, stop_det, bit_in;

  // Bits [1:0] synchronize the pins, bit [2] holds the previous synced value for edges.
  assign sioc_rise = sioc_sync_q[1] & ~sioc_sync_q[2];
  assign sioc_fall = ~sioc_sync_q[1] & sioc_sync_q[2];
  assign sioc_hi   = sioc_sync_q[1] & sioc_sync_q[2];
  assign bit_in    = siod_sync_q[1];
  assign start_det = sioc_hi & ~siod_sync_q[1] & siod_sync_q[2];
  assign stop_det  = sioc_hi & siod_sync_q[1] & ~siod_sync_q[2];
  assign rx_byte   = {shift_q, bit_in};

  always_comb begin
    sioc_sync_d = {sioc_sync_q[1:0], sioc};
    siod_sync_d = {siod_sync_q[1:0], siod};
    state_d     = state_q;
    ack_d       = ack_q;
    bit_cnt_d   = bit_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    wr_en_d     = 1'b0;
    id_err_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_count_d  = wr_count_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    reg_we      = 1'b0;
    if (start_det || stop_det) begin
      state_d   = start_det ? S_ID : S_IDLE;
      bit_cnt_d = 4'd0;
      ack_d     = A_NONE;
      ack_cnt_d = 8'd0;
    end else begin
      case (ack_q)
        A_WAIT: if (sioc_fall) begin
          ack_d     = A_COUNT;
          ack_cnt_d = 8'd0;
        end
        A_COUNT: begin
          if (ack_cnt_q != 8'hFF) ack_cnt_d = ack_cnt_q + 8'd1;
          if (ack_cnt_q >= ACK_LAST) ack_d = A_DRIVE;
        end
        A_DRIVE: if (sioc_fall) begin
          ack_d     = A_NONE;
          ack_cnt_d = 8'd0;
        end
        default: ;
      endcase
      if (sioc_rise && state_q != S_IDLE) begin
        bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
        if (bit_cnt_q < 4'd8) shift_d = {shift_q[5:0], bit_in};
        if (bit_cnt_q == 4'd7) begin
          case (state_q)
            S_ID: begin
              if (rx_byte == DEV_ID) begin
                state_d = S_ADDR;
                ack_d   = A_WAIT;
              end else begin
                state_d  = S_IGNORE;
                id_err_d = 1'b1;
              end
            end
            S_ADDR: begin
              addr_d  = rx_byte;
              state_d = S_DATA;
              ack_d   = A_WAIT;
            end
            S_DATA: begin
              reg_we     = 1'b1;
              wr_en_d    = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_byte;
              wr_count_d = wr_count_q + 16'd1;
              state_d    = S_IGNORE;
              ack_d      = A_WAIT;
            end
            default: ;
          endcase
        end
      end
    end
    // Registered so the pin driver is glitch-free and released asynchronously by reset.
    siod_oe_d = (ack_d == A_DRIVE);
  end

  always_ff @(posedge ov7670_clk50 or posedge reg_conf_rst) begin
    if (reg_conf_rst) begin
      sioc_sync_q <= 3'b111;
      siod_sync_q <= 3'b111;
      state_q     <= S_IDLE;
      ack_q       <= A_NONE;
      bit_cnt_q   <= 4'd0;
      ack_cnt_q   <= 8'd0;
      siod_oe_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      id_err_q    <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      wr_count_q  <= 16'd0;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      siod_oe_q   <= siod_oe_d;
      wr_en_q     <= wr_en_d;
      id_err_q    <= id_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_ff @(posedge ov7670_clk50) begin
    shift_q <= shift_d;
    addr_q  <= addr_d;
  end

  always_ff @(posedge ov7670_clk50 or posedge reg_conf_rst) begin
    if (reg_conf_rst) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= REG_INIT;
    end else if (reg_we) begin
      regs_q[addr_q] <= rx_byte;
    end
  end

  assign siod     = siod_oe_q ? 1'b0 : 1'bz;
  assign busy     = (state_q != S_IDLE);
  assign wr_en    = wr_en_q;
  assign id_err   = id_err_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;
  assign rd_data  = regs_q[rd_addr];
endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a compressed-timing SCCB sender (10-cycle bit,
// SIOC high on counts 4..6, data changes 3 cycles after SIOC fall) drives the bus.
module tb_sccb_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sioc = 1'b1;
  logic        tb_oe = 1'b1;
  logic        tb_val = 1'b1;
  logic [7:0]  rd_addr = 8'h00;
  wire         siod;
  logic        busy, wr_en, id_err;
  logic [7:0]  wr_addr, wr_data, rd_data;
  logic [15:0] wr_count;

  int vecs = 0;
  int miscompares = 0;
  int wr_en_cnt = 0, id_err_cnt = 0, overlap_cnt = 0, dut_low_cnt = 0;
  int we0, ie0, dl0;

  assign siod = tb_oe ? tb_val : 1'bz;
  pullup (siod);

  sccb_responder #(.DEV_ID(8'h42), .ACK_DLY(4), .REG_INIT(8'h00)) dut (
    .ov7670_clk50(clk), .reg_conf_rst(rst), .sioc(sioc), .siod(siod),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .id_err(id_err), .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) wr_en_cnt <= wr_en_cnt + 1;
    if (id_err) id_err_cnt <= id_err_cnt + 1;
    if (tb_oe && tb_val && siod !== 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (!(tb_oe && !tb_val) && siod === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One SCCB bit; rel releases SIOD for the ACK slot, rst_mid pulses reset inside it.
  task automatic send_bit(input logic v, input logic rel, input logic do_chk, input logic exp,
                          input string tag, input logic rst_mid);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tb_oe  = !rel;
        tb_val = v;
      end
      if (c == 4) sioc = 1'b1;
      if (c == 5 && do_chk) chk(tag, {31'd0, siod}, {31'd0, exp});
      if (c == 6 && rst_mid) begin
        rst = 1'b1;
        #1;
        chk("rst_siod_release", {31'd0, siod}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      end
      if (c == 7) sioc = 1'b0;
      if (c == 9 && rst_mid) rst = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic acked, input string tag,
                           input logic rst_mid);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, 1'b0, 1'b0, tag, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1, !acked, tag, rst_mid);
  endtask

  task automatic send_start();
    @(negedge clk);
    tb_oe = 1'b1; tb_val = 1'b1; sioc = 1'b1;
    wait_neg(2);
    tb_val = 1'b0;
    wait_neg(3);
    sioc = 1'b0;
    wait_neg(1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_stop();
    @(negedge clk);
    tb_oe = 1'b1; tb_val = 1'b0;
    wait_neg(1);
    sioc = 1'b1;
    wait_neg(3);
    tb_val = 1'b1;
    wait_neg(3);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic txn(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                     input logic acked, input logic with_data, input string tag);
    send_start();
    send_byte(id, acked, tag, 1'b0);
    send_byte(a, acked, tag, 1'b0);
    if (with_data) send_byte(d, acked, tag, 1'b0);
    send_stop();
  endtask

  initial begin
    wait_neg(5);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_id_err", {31'd0, id_err}, 32'd0);
    chk("reset_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
    chk("reset_wr_count", {16'd0, wr_count}, 32'd0);
    chk("reset_siod", {31'd0, siod}, 32'd1);
    rd_chk(8'h12, 8'h00, "reset_reg12");
    rst = 1'b0;
    wait_neg(5);

    // Basic write 0x42 / 0x12 / 0x80.
    we0 = wr_en_cnt; ie0 = id_err_cnt;
    txn(8'h42, 8'h12, 8'h80, 1'b1, 1'b1, "w12_ack");
    chk("w12_wr_en_pulses", wr_en_cnt - we0, 1);
    chk("w12_id_err", id_err_cnt - ie0, 0);
    chk("w12_wr_addr", {24'd0, wr_addr}, 32'h12);
    chk("w12_wr_data", {24'd0, wr_data}, 32'h80);
    chk("w12_wr_count", {16'd0, wr_count}, 32'd1);
    rd_chk(8'h12, 8'h80, "w12_rd");

    // Foreign ID 0x60: no ACK, no write.
    we0 = wr_en_cnt; ie0 = id_err_cnt; dl0 = dut_low_cnt;
    txn(8'h60, 8'h11, 8'h01, 1'b0, 1'b1, "id60_noack");
    chk("id60_id_err", id_err_cnt - ie0, 1);
    chk("id60_dut_low", dut_low_cnt - dl0, 0);
    chk("id60_wr_en", wr_en_cnt - we0, 0);
    rd_chk(8'h11, 8'h00, "id60_rd11");

    // Read ID 0x43 is rejected like any other mismatch.
    we0 = wr_en_cnt; ie0 = id_err_cnt; dl0 = dut_low_cnt;
    txn(8'h43, 8'h12, 8'h55, 1'b0, 1'b1, "id43_noack");
    chk("id43_id_err", id_err_cnt - ie0, 1);
    chk("id43_dut_low", dut_low_cnt - dl0, 0);
    chk("id43_wr_count", {16'd0, wr_count}, 32'd1);
    rd_chk(8'h12, 8'h80, "id43_rd12");

    // Stop before data byte, then the full write.
    we0 = wr_en_cnt;
    txn(8'h42, 8'h3A, 8'h00, 1'b1, 1'b0, "part_ack");
    chk("part_wr_en", wr_en_cnt - we0, 0);
    rd_chk(8'h3A, 8'h00, "part_rd3a");
    txn(8'h42, 8'h3A, 8'h04, 1'b1, 1'b1, "w3a_ack");
    rd_chk(8'h3A, 8'h04, "w3a_rd");
    chk("w3a_wr_count", {16'd0, wr_count}, 32'd2);

    // Back-to-back writes, addr = i mod 256, data = ~i.
    we0 = wr_en_cnt;
    for (int i = 0; i < 262; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      txn(8'h42, iv, ~iv, 1'b1, 1'b1, "bulk_ack");
    end
    chk("bulk_wr_en", wr_en_cnt - we0, 262);
    chk("bulk_wr_count", {16'd0, wr_count}, 32'd264);
    rd_chk(8'h05, 8'hFA, "bulk_rd05");
    rd_chk(8'h12, 8'hED, "bulk_rd12");
    rd_chk(8'hFF, 8'h00, "bulk_rdff");
    chk("bulk_overlap", overlap_cnt, 0);

    // Reset during the ID ACK, remainder of that write must be ignored.
    we0 = wr_en_cnt;
    send_start();
    send_byte(8'h42, 1'b1, "rst_id_ack", 1'b1);
    rd_chk(8'h05, 8'h00, "rst_rd05");
    rd_chk(8'h3A, 8'h00, "rst_rd3a");
    send_byte(8'h40, 1'b0, "rst_tail_noack", 1'b0);
    send_byte(8'hD0, 1'b0, "rst_tail_noack", 1'b0);
    send_stop();
    chk("rst_tail_wr_en", wr_en_cnt - we0, 0);
    rd_chk(8'h40, 8'h00, "rst_tail_rd40");
    txn(8'h42, 8'h40, 8'hD0, 1'b1, 1'b1, "post_rst_ack");
    chk("post_rst_wr_count", {16'd0, wr_count}, 32'd1);
    chk("post_rst_wr_addr", {24'd0, wr_addr}, 32'h40);
    chk("post_rst_wr_data", {24'd0, wr_data}, 32'hD0);
    rd_chk(8'h40, 8'hD0, "post_rst_rd40");
    chk("final_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
